ild_seq_div: RTL and testbench
==============================

ILD_SEQ_DIV -- requirements
Module: ild_seq_div

Interface
REQ-001 Parameter WIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 Parameter ITER, default 8, range 1..WIDTH: maximum number of subtract iterations; values below WIDTH give an approximate quotient.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  dividend/divisor pair offered.
REQ-006 in_ready  output  1  block can accept a pair.
REQ-007 x  input  WIDTH  dividend, unsigned.
REQ-008 y  input  WIDTH  divisor, unsigned.
REQ-009 out_valid  output  1  result held on q (and rem).
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 q  output  WIDTH  quotient, approximate if truncated by ITER.
REQ-012 dbz  output  1  the current result came from a y==0 request.

Function
REQ-013 FSM states are IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE with in_valid=1 at an edge: latch y, r<=x, q<=0, cnt<=0, dbz<=(y==0); go to CALC if y!=0, else go to DONE with q<=all-ones.
REQ-015 CALC, termination: if r<y or cnt==ITER, go to DONE with q and r unchanged.
REQ-016 CALC, update step, in order:
- kr = leading-one index of r; ky = leading-one index of y.
- s = kr-ky, minus 1 if (y<<s) > r.
- q <= q | (1<<s); r <= r-(y<<s); cnt <= cnt+1.
REQ-017 The y<<s product uses WIDTH+1 bits internally; no overflow is permitted.
REQ-018 Latency: out_valid rises N+2 edges after the accept edge, where N = number of iterations performed (N <= ITER); a y==0 request gives 1 edge.
REQ-019 DONE: q, rem and dbz are held stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 at an edge: go to IDLE; a new request is accepted no earlier than the following edge (no bypass).
REQ-021 in_valid while not IDLE is ignored; x and y are sampled only at the accept edge.
REQ-022 x==0, y!=0: q=0 after 2 edges.
REQ-023 ITER>=WIDTH: q = floor(x/y) and rem = x mod y exactly.

Reset
REQ-024 rst_n=0 at an edge: state<=IDLE; q, r, cnt, dbz <= 0; any in-flight operation is discarded.
REQ-025 Reset values: out_valid=0 and in_ready=1 from the first edge after rst_n=0.

Configuration
REQ-026 Macro ILD_REM_OUT_EN, when defined: adds output port rem (WIDTH bits, remainder r, valid with out_valid); for y==0, rem=x.
REQ-027 Macro ILD_REM_OUT_EN, when undefined: port rem is absent; r stays internal only; all other behaviour is identical.

Structure
REQ-028 Package ild_pkg: state enum type (IDLE, CALC, DONE) and the default WIDTH and ITER constants.
REQ-029 Sub-module lod_w: combinational leading-one index detector, WIDTH in, clog2(WIDTH) out, output 0 for input 0; instantiated twice, for r and for y.

Verification
REQ-030 x=200, y=3, ITER=8 -> q=66, rem=2, dbz=0; out_valid rises 4 edges after accept.
REQ-031 x=200, y=3, ITER=1 -> q=64, rem=8; out_valid rises 3 edges after accept.
REQ-032 x=17, y=0 -> q=8'hFF, rem=17, dbz=1; out_valid rises 1 edge after accept.
REQ-033 x=5, y=9 -> q=0, rem=5 after 2 edges; hold out_ready=0 for 5 cycles -> q, rem and out_valid are stable, and in_ready=0 throughout.
REQ-034 rst_n=0 asserted mid-CALC on x=255, y=1 -> state IDLE next edge, out_valid=0, q=0; the following request x=255, y=1 -> q=255, rem=0.
REQ-035 Exhaustive sweep, all 65536 pairs, ITER=8, back-to-back with random out_ready -> q = x/y and rem = x%y for every y!=0.

Source files
------------

// File: rtl/ild_pkg.sv
// Shared types and default sizing for the sequential shift-subtract divider.
package ild_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ITER_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ild_seq_div_lod_w.sv
// Leading-one index detector: returns the index of the highest set bit, 0 for a zero input.
module lod_w #(
    parameter int WIDTH = 8,
    parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] a,
    output logic [IW-1:0]    idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/ild_seq_div.sv
// Sequential unsigned divider that retires one quotient bit per aligned subtract.
// Optional remainder output port enabled by defining ILD_REM_OUT_EN.
//
// state | meaning
// IDLE  | waiting for a dividend/divisor pair, in_ready high
// CALC  | aligned subtract iterations, bounded by ITER
// DONE  | result held until out_ready
module ild_seq_div
    import ild_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
`ifdef ILD_REM_OUT_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic             dbz
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] y_r;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    kr;
    logic [IW-1:0]    ky;
    logic [IW-1:0]    s_raw;
    logic [IW-1:0]    s;
    logic [WIDTH:0]   y_sh_raw;
    logic [WIDTH:0]   y_sh;

    lod_w #(.WIDTH(WIDTH), .IW(IW)) u_lod_r (.a(r),   .idx(kr));
    lod_w #(.WIDTH(WIDTH), .IW(IW)) u_lod_y (.a(y_r), .idx(ky));

    // Aligning leading ones may overshoot r by one position; back off a bit if so.
    always_comb begin
        s_raw    = kr - ky;
        y_sh_raw = {1'b0, y_r} << s_raw;
        if (y_sh_raw > {1'b0, r}) begin
            s    = s_raw - 1'b1;
            y_sh = y_sh_raw >> 1;
        end else begin
            s    = s_raw;
            y_sh = y_sh_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            q         <= '0;
            r         <= '0;
            y_r       <= '0;
            cnt       <= '0;
            dbz       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_r      <= y;
                        r        <= x;
                        cnt      <= '0;
                        dbz      <= (y == '0);
                        in_ready <= 1'b0;
                        if (y == '0) begin
                            q         <= '1;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            q     <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if ((r < y_r) || (cnt == CW'(ITER))) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        q   <= q | (WIDTH'(1) << s);
                        r   <= WIDTH'({1'b0, r} - y_sh);
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef ILD_REM_OUT_EN
    assign rem = r;
`endif

endmodule

// File: tb/tb_ild_seq_div.sv
// Randomized bench for ild_seq_div: one full-precision instance (ITER=8) and one truncated (ITER=1).
module tb_ild_seq_div;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      in_valid, in_ready, out_valid, out_ready, dbz;
    logic [1:0][7:0] xs, ys, qs, rems;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ild_seq_div #(.WIDTH(8), .ITER(8)) dut_full (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(xs[0]), .y(ys[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .q(qs[0]),
`ifdef ILD_REM_OUT_EN
        .rem(rems[0]),
`endif
        .dbz(dbz[0])
    );

    ild_seq_div #(.WIDTH(8), .ITER(1)) dut_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(xs[1]), .y(ys[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .q(qs[1]),
`ifdef ILD_REM_OUT_EN
        .rem(rems[1]),
`endif
        .dbz(dbz[1])
    );

`ifndef ILD_REM_OUT_EN
    assign rems = '0;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Greedy division: each step removes the largest power-of-two multiple of y that fits.
    function automatic void model(input int iter, input int xv, input int yv,
                                  output int qv, output int rv, output int nv);
        int s;
        qv = 0;
        rv = xv;
        nv = 0;
        if (yv == 0) begin
            qv = 255;
            return;
        end
        while (rv >= yv && nv < iter) begin
            s = 0;
            while ((yv << (s + 1)) <= rv) s++;
            qv += (1 << s);
            rv -= (yv << s);
            nv++;
        end
    endfunction

    task automatic do_op(input int sel, input logic [7:0] xv, input logic [7:0] yv, input int hold);
        int eq, er, en, elat, k;
        model((sel == 0) ? 8 : 1, int'(xv), int'(yv), eq, er, en);
        elat = (yv == 0) ? 1 : en + 2;

        k = 0;
        while (!in_ready[sel] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_op", int'(in_ready[sel]), 1);

        in_valid[sel]  = 1'b1;
        xs[sel]        = xv;
        ys[sel]        = yv;
        out_ready[sel] = 1'b0;
        @(negedge clk);
        in_valid[sel] = 1'($urandom_range(0, 1));
        xs[sel]       = 8'($urandom);
        ys[sel]       = 8'($urandom);
        k = 1;
        while (!out_valid[sel] && k < 40) begin
            out_ready[sel] = 1'($urandom_range(0, 1));
            @(negedge clk);
            xs[sel] = 8'($urandom);
            ys[sel] = 8'($urandom);
            k++;
        end
        check("latency", k, elat);
        check("q", int'(qs[sel]), eq);
        check("dbz", int'(dbz[sel]), (yv == 0) ? 1 : 0);
        check("in_ready_busy", int'(in_ready[sel]), 0);
`ifdef ILD_REM_OUT_EN
        check("rem", int'(rems[sel]), er);
`endif

        for (int h = 0; h < hold; h++) begin
            out_ready[sel] = 1'b0;
            in_valid[sel]  = 1'b1;
            @(negedge clk);
            check("hold_valid", int'(out_valid[sel]), 1);
            check("hold_q", int'(qs[sel]), eq);
            check("hold_in_ready", int'(in_ready[sel]), 0);
`ifdef ILD_REM_OUT_EN
            check("hold_rem", int'(rems[sel]), er);
`endif
        end

        out_ready[sel] = 1'b1;
        in_valid[sel]  = 1'b1;
        @(negedge clk);
        check("release_valid", int'(out_valid[sel]), 0);
        check("release_in_ready", int'(in_ready[sel]), 1);
        in_valid[sel]  = 1'b0;
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        xs        = '0;
        ys        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", int'(in_ready[i]), 1);
            check("rst_out_valid", int'(out_valid[i]), 0);
            check("rst_q", int'(qs[i]), 0);
        end
        rst_n = 1'b1;

        do_op(0, 8'd200, 8'd3, 0);
        do_op(1, 8'd200, 8'd3, 0);
        do_op(0, 8'd17, 8'd0, 2);
        do_op(1, 8'd17, 8'd0, 0);
        do_op(0, 8'd5, 8'd9, 5);
        do_op(0, 8'd0, 8'd5, 0);
        do_op(0, 8'd255, 8'd255, 1);
        do_op(0, 8'd1, 8'd255, 0);
        do_op(0, 8'd255, 8'd1, 0);
        do_op(1, 8'd255, 8'd1, 0);

        // Reset in the middle of a long computation.
        in_valid[0] = 1'b1;
        xs[0] = 8'd255;
        ys[0] = 8'd1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid[0]), 0);
        check("midrst_in_ready", int'(in_ready[0]), 1);
        check("midrst_q", int'(qs[0]), 0);
        rst_n = 1'b1;
        do_op(0, 8'd255, 8'd1, 0);

        for (int i = 0; i < 1500; i++) begin
            do_op(0, 8'($urandom), ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom),
                  $urandom_range(0, 3));
        end
        for (int i = 0; i < 300; i++) begin
            do_op(1, 8'($urandom), 8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
